// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage for the RV64I pipeline.
//
// Owns the fetch PC and issues in-order 32-bit fetch requests to instruction memory. Returned
// words are paired with their request address and buffered, then offered to the IF/ID register
// as a valid/pc/instr triple that honours stall_i. A redirect retargets the PC, empties the
// buffer and drops every response still in flight.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   imem_req_valid_o      fetch request valid (handshake = valid & ready)
//   imem_req_ready_i      memory accepts request
//   imem_req_addr_o       64-bit fetch address, 4-byte aligned
//   imem_rsp_valid_i      in-order response valid, always accepted
//   imem_rsp_data_i       32-bit instruction word
//   redirect_i            flush and retarget fetch
//   redirect_pc_i         new fetch PC, bits [1:0] forced to zero
//   stall_i               IF/ID hold; head is not consumed
//   if_valid_o            head instruction valid
//   if_pc_o, if_instr_o   head pc/instr, zero when not valid
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [63:0]   r_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;

  // Tag FIFO: addresses of accepted requests awaiting their response.
  logic [63:0]   r_tag_mem [DEPTH];
  logic [AW-1:0] r_tag_wr;
  logic [AW-1:0] r_tag_rd;

  // Instruction FIFO of {pc, instr}.
  logic [63:0]   r_ipc_mem [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];
  logic [AW-1:0] r_buf_wr;
  logic [AW-1:0] r_buf_rd;

  logic          w_valid;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic          w_req_valid;
  logic          w_hs;
  logic          w_rsp;
  logic          w_keep;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & ~stall_i & ~redirect_i;

  // Credit check: outstanding plus buffered never exceeds DEPTH, so every response accepted
  // by the memory always has a free buffer slot waiting for it.
  assign w_occ       = {1'b0, r_outst} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
  assign w_req_valid = ~rst_i & ~redirect_i & (w_occ < DepthW);
  assign w_hs        = w_req_valid & imem_req_ready_i;

  // Responses with nothing outstanding are spurious and ignored entirely.
  assign w_rsp  = imem_rsp_valid_i & (r_outst != '0);
  assign w_keep = w_rsp & (r_discard == '0) & ~redirect_i;

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_pc;

  assign if_valid_o = w_valid;
  assign if_pc_o    = w_valid ? r_ipc_mem[r_buf_rd] : 64'd0;
  assign if_instr_o = w_valid ? r_ins_mem[r_buf_rd] : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
      r_count   <= '0;
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_buf_wr  <= '0;
      r_buf_rd  <= '0;
    end else begin
      if (redirect_i) begin
        r_pc <= {redirect_pc_i[63:2], 2'b00};
      end else if (w_hs) begin
        r_pc <= r_pc + 64'd4;
      end

      unique case ({w_hs, w_rsp})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase

      if (w_hs) begin
        r_tag_wr <= r_tag_wr + AW'(1);
      end
      if (w_rsp) begin
        r_tag_rd <= r_tag_rd + AW'(1);
      end

      // A response landing in the redirect cycle is already excluded from the new count.
      if (redirect_i) begin
        r_discard <= r_outst - CW'(w_rsp);
      end else if (w_rsp && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end

      if (redirect_i) begin
        r_count  <= '0;
        r_buf_wr <= '0;
        r_buf_rd <= '0;
      end else begin
        unique case ({w_keep, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_keep) begin
          r_buf_wr <= r_buf_wr + AW'(1);
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + AW'(1);
        end
      end
    end
  end

  // Storage arrays carry data only; validity is tracked by the pointers and counters above.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_keep) begin
      r_ipc_mem[r_buf_wr] <= r_tag_mem[r_tag_rd];
      r_ins_mem[r_buf_wr] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-programmable memory model feeds the DUT,
// expected {pc, instr} pairs are queued by each scenario and compared whenever the DUT hands
// an instruction to IF/ID. Instruction word for address A is ~A[31:0].
module tb_if_fetch_unit;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'd0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'd0;
  logic        stall_i = 1'b0;
  logic        if_valid_o;
  logic [63:0] if_pc_o;
  logic [31:0] if_instr_o;

  if_fetch_unit #(.RESET_PC(ResetPc), .DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [95:0] exp_q[$];
  logic [63:0] req_log[$];
  int          lat   = 1;
  int          cyc   = 0;
  int          pops  = 0;
  int          total = 0;
  int          bad   = 0;

  // Memory model and scoreboard. Inputs change at the falling edge; everything is sampled
  // 1 time unit before the rising edge, when inputs and DUT outputs are settled.
  initial begin
    mem_t        m;
    logic [95:0] e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_i || mem_q.size() == 0 || mem_q[0].due > cyc) begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'd0;
      end else begin
        m = mem_q.pop_front();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = ~m.addr[31:0];
      end
      #4;
      if (rst_i) begin
        mem_q.delete();
        imem_rsp_valid_i = 1'b0;
      end else begin
        if (imem_req_valid_o && imem_req_ready_i) begin
          mem_q.push_back('{addr: imem_req_addr_o, due: cyc + lat});
          req_log.push_back(imem_req_addr_o);
        end
        if (if_valid_o && !stall_i && !redirect_i) begin
          pops++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected pc=%h instr=%h expected no output", if_pc_o, if_instr_o);
          end else begin
            e = exp_q.pop_front();
            if (if_pc_o !== e[95:32] || if_instr_o !== e[31:0]) begin
              bad++;
              $display("FAIL sb_out pc=%h instr=%h expected pc=%h instr=%h",
                       if_pc_o, if_instr_o, e[95:32], e[31:0]);
            end
          end
        end else if (!if_valid_o) begin
          total++;
          if (if_pc_o !== 64'd0 || if_instr_o !== 32'd0) begin
            bad++;
            $display("FAIL idle_zero pc=%h instr=%h expected 0/0", if_pc_o, if_instr_o);
          end
        end
      end
    end
  end

  task automatic push_stream(input logic [63:0] start, input int n);
    logic [63:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, ~pc[31:0]});
      pc = pc + 64'd4;
    end
  endtask

  task automatic rst_on();
    @(negedge clk_i);
    rst_i = 1'b1;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    imem_req_ready_i = 1'b1;
    exp_q.delete();
    req_log.delete();
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  // Returns at the start of cycle 1 after reset release.
  task automatic rst_off();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_on();
    #2;
    chk_bit("rst_req_valid", imem_req_valid_o, 1'b0);
    chk_bit("rst_if_valid", if_valid_o, 1'b0);
    chk64("rst_if_pc", if_pc_o, 64'd0);
    chk64("rst_if_instr", {32'd0, if_instr_o}, 64'd0);
  endtask

  task automatic test_stream();
    int p0;
    rst_on();
    lat = 1;
    push_stream(ResetPc, 64);
    p0 = pops;
    rst_off();
    #2;
    chk_bit("first_req_valid", imem_req_valid_o, 1'b1);
    chk64("first_req_addr", imem_req_addr_o, ResetPc);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk_i);
      #2;
      chk_bit($sformatf("stream_valid_c%0d", c), if_valid_o, (c >= 3));
    end
    chk64("stream_req_addr3", req_log[3], ResetPc + 64'd12);
    total++;
    if (pops - p0 < 9) begin
      bad++;
      $display("FAIL stream_pops act=%0d exp>=9", pops - p0);
    end
  endtask

  task automatic test_stall();
    int p0;
    rst_on();
    lat = 1;
    push_stream(ResetPc, 64);
    stall_i = 1'b1;
    p0 = pops;
    rst_off();
    for (int c = 1; c <= 10; c++) begin
      #2;
      if (c >= 3) begin
        chk_bit($sformatf("stall_valid_c%0d", c), if_valid_o, 1'b1);
        chk64($sformatf("stall_pc_c%0d", c), if_pc_o, ResetPc);
      end
      @(negedge clk_i);
    end
    #2;
    chk_bit("full_req_blocked", imem_req_valid_o, 1'b0);
    chk64("stall_req_count", 64'(req_log.size()), 64'd4);
    stall_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk_bit($sformatf("drain_valid_%0d", c), if_valid_o, 1'b1);
      @(negedge clk_i);
    end
    total++;
    if (pops - p0 != 6) begin
      bad++;
      $display("FAIL drain_pops act=%0d exp=6", pops - p0);
    end
  endtask

  task automatic test_redirect();
    rst_on();
    lat = 3;
    rst_off();
    @(negedge clk_i);
    @(negedge clk_i);
    // Cycle 3: two requests outstanding, neither answered yet.
    redirect_i = 1'b1;
    redirect_pc_i = 64'h0000_0000_8000_0103;
    push_stream(64'h0000_0000_8000_0100, 64);
    #2;
    chk64("redir_pre_reqs", 64'(req_log.size()), 64'd2);
    chk_bit("redir_no_req", imem_req_valid_o, 1'b0);
    req_log.delete();
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk_i);
      redirect_i = 1'b0;
      #2;
      if (c == 4) begin
        chk_bit("redir_req_valid", imem_req_valid_o, 1'b1);
        chk64("redir_req_addr", imem_req_addr_o, 64'h0000_0000_8000_0100);
      end
      chk_bit($sformatf("redir_valid_c%0d", c), if_valid_o, (c == 8));
    end
    chk64("redir_head_pc", if_pc_o, 64'h0000_0000_8000_0100);
    repeat (6) @(negedge clk_i);
  endtask

  task automatic test_redirect_rsp_stall();
    int  p0;
    logic hit;
    rst_on();
    lat = 3;
    push_stream(ResetPc, 64);
    rst_off();
    repeat (5) @(negedge clk_i);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_i);
      #1;
      hit = imem_rsp_valid_i;
    end
    chk_bit("rsp_seen", hit, 1'b1);
    redirect_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 64'h0000_0000_0000_1000;
    exp_q.delete();
    push_stream(64'h0000_0000_0000_1000, 64);
    p0 = pops;
    #1;
    chk_bit("rr_no_req", imem_req_valid_o, 1'b0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    #2;
    chk_bit("rr_valid_after", if_valid_o, 1'b0);
    @(negedge clk_i);
    stall_i = 1'b0;
    repeat (12) @(negedge clk_i);
    total++;
    if (pops - p0 < 4) begin
      bad++;
      $display("FAIL rr_pops act=%0d exp>=4", pops - p0);
    end
  endtask

  task automatic test_wrap();
    rst_on();
    lat = 1;
    push_stream(64'hFFFF_FFFF_FFFF_FFFC, 64);
    rst_off();
    redirect_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    chk_bit("wrap_no_req", imem_req_valid_o, 1'b0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    #2;
    chk64("wrap_addr0", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk_i);
    #2;
    chk64("wrap_addr1", imem_req_addr_o, 64'd0);
    @(negedge clk_i);
    #2;
    chk64("wrap_valid_pc", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk64("wrap_log1", req_log[1], 64'd0);
    repeat (6) @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    int p0;
    rst_on();
    lat = 1;
    push_stream(ResetPc, 64);
    rst_off();
    repeat (8) @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk_bit("arst_req_valid", imem_req_valid_o, 1'b0);
    chk_bit("arst_if_valid", if_valid_o, 1'b0);
    chk64("arst_if_pc", if_pc_o, 64'd0);
    chk64("arst_if_instr", {32'd0, if_instr_o}, 64'd0);
    exp_q.delete();
    req_log.delete();
    push_stream(ResetPc, 64);
    p0 = pops;
    @(negedge clk_i);
    rst_off();
    #2;
    chk64("arst_restart_addr", imem_req_addr_o, ResetPc);
    repeat (8) @(negedge clk_i);
    total++;
    if (pops - p0 < 5) begin
      bad++;
      $display("FAIL arst_pops act=%0d exp>=5", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    rst_on();
    lat = 2;
    push_stream(ResetPc, 200);
    p0 = pops;
    rst_off();
    for (int c = 0; c < 80; c++) begin
      imem_req_ready_i = 1'($urandom_range(0, 1));
      stall_i = ($urandom_range(0, 3) == 0);
      @(negedge clk_i);
    end
    imem_req_ready_i = 1'b1;
    stall_i = 1'b0;
    repeat (6) @(negedge clk_i);
    total++;
    if (pops - p0 < 15) begin
      bad++;
      $display("FAIL b2b_pops act=%0d exp>=15", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp_stall();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
